mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, multi-cycle backing memory between instruction fetch (IF) and data access (MEM).
//  Grants one requester at a time and drives a req/ack handshake to the memory.
//  Returns read data with a one-cycle valid pulse; raises per-requester stall to freeze the pipeline.
//  Data access has priority; a streak counter bounds fetch starvation. A no-ack timeout traps to an error state.
// PARAMETERS
//  ADDR_W         32  address width, both requesters and memory
//  DATA_W         32  data width
//  MAX_DM_STREAK   4  consecutive contested DM grants before IF is forced (>=1)
//  TIMEOUT        16  max cycles in a busy state without mem_ack_i before error (>=2)
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       reset, asynchronous, active-high
//  if_req_i     in   1       fetch request; held with if_addr_i stable until if_valid_o
//  if_addr_i    in   ADDR_W  fetch address
//  if_rdata_o   out  DATA_W  fetched word, valid while if_valid_o
//  if_valid_o   out  1       one-cycle fetch-complete pulse
//  if_stall_o   out  1       if_req_i & ~if_valid_o, or error state
//  dm_req_i     in   1       data request; held with addr/we/wdata stable until dm_valid_o
//  dm_we_i      in   1       1 = store, 0 = load
//  dm_addr_i    in   ADDR_W  data address
//  dm_wdata_i   in   DATA_W  store data
//  dm_rdata_o   out  DATA_W  load data, valid while dm_valid_o; holds old value after a store
//  dm_valid_o   out  1       one-cycle access-complete pulse (loads and stores)
//  dm_stall_o   out  1       dm_req_i & ~dm_valid_o, or error state
//  mem_req_o    out  1       memory request; level, held until mem_ack_i
//  mem_we_o     out  1       memory write enable, stable while mem_req_o
//  mem_addr_o   out  ADDR_W  memory address, stable while mem_req_o
//  mem_wdata_o  out  DATA_W  memory write data
//  mem_ack_i    in   1       memory done; sampled only while mem_req_o=1
//  mem_rdata_i  in   DATA_W  memory read data, valid with mem_ack_i
//  err_o        out  1       sticky timeout flag
// BEHAVIOUR
//  Reset:
//   - All registered outputs are 0, state is IDLE, and both counters are 0.
//   - Reset applied mid-access drops mem_req_o immediately (async); the access is abandoned.
//  States: IDLE, BUSY_IF, BUSY_DM, ERR.
//  IDLE:
//   - A requester is eligible if its req_i=1 and its valid_o=0 this cycle; the valid cycle consumes the request.
//   - If only one requester is eligible, grant it.
//   - If both are eligible, grant DM, unless streak==MAX_DM_STREAK, in which case grant IF.
//   - On grant, latch addr/we/wdata into the mem_*_o registers and set mem_req_o=1 from the next cycle.
//   - Go to BUSY_IF or BUSY_DM.
//  BUSY_x:
//   - Hold mem_req_o and its operands.
//   - wait_cnt increments each cycle.
//   - On mem_ack_i: clear mem_req_o, register mem_rdata_i into x_rdata_o (loads and fetches only), pulse x_valid_o next cycle, return to IDLE.
//   - If wait_cnt reaches TIMEOUT-1 without ack: go to ERR.
//  ERR:
//   - mem_req_o=0, err_o=1, both stalls forced to 1, no valid pulses.
//   - Exit only by reset.
//  Latency:
//   - Request sampled in IDLE at cycle N; mem_req_o is high from N+1.
//   - Ack at cycle M; valid_o and rdata at M+1; IDLE at M+1, so the next grant is at M+1 and its mem_req_o at M+2.
//   - Minimum 3 cycles per access, with a one-cycle bubble between accesses.
//  Streak counter:
//   - DM grant with if_req_i=1: +1, saturating at MAX_DM_STREAK.
//   - IF grant: cleared to 0.
//   - DM grant with if_req_i=0: unchanged.
//  Widths: wait_cnt is $clog2(TIMEOUT) bits; streak is $clog2(MAX_DM_STREAK+1) bits; no wrap-around.
//  An ack in the same cycle as the TIMEOUT-1 limit counts as success.
//  mem_ack_i outside BUSY is ignored.
// STRUCTURE
//  Package mem_arb_pkg:
//   - arb_state_e {IDLE, BUSY_IF, BUSY_DM, ERR}
//   - grant_e {GNT_NONE, GNT_IF, GNT_DM}
//  Sub-module arb_pick (combinational):
//   - inputs: eligibility bits and streak_sat
//   - output: grant_e
//  Everything else (FSM, counters, operand/rdata registers) lives in mem_port_arbiter.
// TESTING
//  1. IF only, addr 0x100, ack 2 cycles after mem_req_o, rdata 0xDEADBEEF -> if_valid_o one cycle with 0xDEADBEEF; if_stall_o high until then.
//  2. IF and DM both held: DM store 0x200/0x55 -> 4 DM grants, 5th grant to IF; streak clears; mem_we_o=1 only on DM.
//  3. DM load with ack 0 cycles late -> dm_valid_o at M+1; if_req_i asserted in DM's valid cycle is granted that cycle.
//  4. No ack for TIMEOUT=16 cycles -> ERR at cycle 16, err_o=1 sticky, mem_req_o=0, both stalls 1; a late ack is ignored.
//  5. rst_i pulsed mid-BUSY_DM -> mem_req_o=0 in the same cycle, no valid pulse, all outputs 0; next request proceeds normally.
//  6. Stray mem_ack_i in IDLE -> no state change, no valid pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter.
//   arb_state_e : arbiter FSM states
//   grant_e     : combinational grant decision from arb_pick
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        ERR     = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } grant_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection between fetch (IF) and data (DM) requesters.
// Ports:
//   if_elig_i    : IF has a pending, unconsumed request
//   dm_elig_i    : DM has a pending, unconsumed request
//   streak_sat_i : DM has won MAX_DM_STREAK contested grants in a row
//   gnt_o        : chosen requester, GNT_NONE when neither is eligible
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_elig_i,
    input  logic   dm_elig_i,
    input  logic   streak_sat_i,
    output grant_e gnt_o
);

    always_comb begin
        gnt_o = GNT_NONE;
        if (if_elig_i && dm_elig_i) begin
            // DM wins contests until the streak saturates, then IF gets one turn.
            gnt_o = streak_sat_i ? GNT_IF : GNT_DM;
        end else if (dm_elig_i) begin
            gnt_o = GNT_DM;
        end else if (if_elig_i) begin
            gnt_o = GNT_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported multi-cycle memory between instruction fetch and data access.
// Ports:
//   clk_i, rst_i                      : clock, async active-high reset
//   if_req_i/if_addr_i                : fetch request (held until if_valid_o)
//   if_rdata_o/if_valid_o/if_stall_o  : fetch result, one-cycle done pulse, pipeline stall
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i : data request (held until dm_valid_o)
//   dm_rdata_o/dm_valid_o/dm_stall_o  : load result, one-cycle done pulse, pipeline stall
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : level request and operands to memory
//   mem_ack_i/mem_rdata_i             : memory completion and read data
//   err_o                             : sticky no-ack timeout flag
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_DM_STREAK = 4,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);

    localparam int unsigned WAIT_W   = $clog2(TIMEOUT);
    localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);

    localparam logic [WAIT_W-1:0]   WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    arb_state_e          state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic                dm_valid_q, dm_valid_d;

    logic   if_elig, dm_elig, streak_sat, in_err;
    grant_e gnt;

    // A requester whose valid pulse is showing this cycle has already been served.
    assign if_elig    = if_req_i & ~if_valid_q;
    assign dm_elig    = dm_req_i & ~dm_valid_q;
    assign streak_sat = (streak_q == STREAK_MAX);
    assign in_err     = (state_q == ERR);

    arb_pick u_pick (
        .if_elig_i    (if_elig),
        .dm_elig_i    (dm_elig),
        .streak_sat_i (streak_sat),
        .gnt_o        (gnt)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                unique case (gnt)
                    GNT_IF: begin
                        state_d    = BUSY_IF;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = if_addr_i;
                        streak_d   = '0;
                    end
                    GNT_DM: begin
                        state_d     = BUSY_DM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dm_we_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        // Only count DM wins that left a fetch waiting.
                        if (if_req_i && !streak_sat) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
            BUSY_IF, BUSY_DM: begin
                // Ack on the limit cycle still completes the access.
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    wait_d    = '0;
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = mem_rdata_i;
                        if_valid_d = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata_i;
                        end
                        dm_valid_d = 1'b1;
                    end
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d   = ERR;
                    mem_req_d = 1'b0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                // ERR is terminal until reset.
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_valid_o  = if_valid_q;
    assign dm_valid_o  = dm_valid_q;
    assign err_o       = in_err;
    assign if_stall_o  = (if_req_i & ~if_valid_q) | in_err;
    assign dm_stall_o  = (dm_req_i & ~dm_valid_q) | in_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid, if_stall;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_valid, dm_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .MAX_DM_STREAK (4),
        .TIMEOUT       (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata),
        .if_valid_o  (if_valid),
        .if_stall_o  (if_stall),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_rdata_o  (dm_rdata),
        .dm_valid_o  (dm_valid),
        .dm_stall_o  (dm_stall),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .err_o       (err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
        n_cmp++; if ({if_valid, dm_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_valid: got %b want 00", {if_valid, dm_valid}); end
        n_cmp++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h/%h want 0/0", if_rdata, dm_rdata); end
        n_cmp++; if (mem_addr !== 32'h0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ops: got %h/%b want 0/0", mem_addr, mem_we); end
        n_cmp++; if ({if_stall, dm_stall} !== 2'b00) begin n_fail++; $display("FAIL rst_stall: got %b want 00", {if_stall, dm_stall}); end
        rst = 1'b0;
        tick();
    endtask

    // Fetch 0x100, ack two cycles after mem_req rises.
    task automatic test_if_fetch();
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        n_cmp++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL t1_stall_pre: got %b want 1", if_stall); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin n_fail++; $display("FAIL t1_grant: got req=%b addr=%h we=%b want 1/100/0", mem_req, mem_addr, mem_we); end
        n_cmp++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL t1_stall_busy: got %b want 1", if_stall); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL t1_hold: got req=%b valid=%b want 1/0", mem_req, if_valid); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t1_done: got valid=%b rdata=%h want 1/deadbeef", if_valid, if_rdata); end
        n_cmp++; if (mem_req !== 1'b0 || if_stall !== 1'b0) begin n_fail++; $display("FAIL t1_release: got req=%b stall=%b want 0/0", mem_req, if_stall); end
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL t1_pulse: got %b want 0", if_valid); end
    endtask

    task automatic test_stray_ack();
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        tick();
        mem_ack = 1'b0;
        n_cmp++; if ({if_valid, dm_valid, mem_req} !== 3'b000) begin n_fail++; $display("FAIL t6_stray: got %b want 000", {if_valid, dm_valid, mem_req}); end
        n_cmp++; if (if_rdata !== 32'hDEADBEEF || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL t6_rdata: got %h/%h want deadbeef/0", if_rdata, dm_rdata); end
        tick();
    endtask

    // Zero-latency DM load, then IF raised in DM's valid cycle is granted immediately.
    task automatic test_back_to_back();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_we !== 1'b0) begin n_fail++; $display("FAIL t3_grant: got req=%b addr=%h we=%b want 1/300/0", mem_req, mem_addr, mem_we); end
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        n_cmp++; if (dm_valid !== 1'b1 || dm_rdata !== 32'hCAFEF00D || mem_req !== 1'b0) begin n_fail++; $display("FAIL t3_done: got valid=%b rdata=%h req=%b want 1/cafef00d/0", dm_valid, dm_rdata, mem_req); end
        mem_ack = 1'b0; dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h400;
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h400 || dm_valid !== 1'b0) begin n_fail++; $display("FAIL t3_if_grant: got req=%b addr=%h dvalid=%b want 1/400/0", mem_req, mem_addr, dm_valid); end
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_rdata !== 32'h11112222) begin n_fail++; $display("FAIL t3_if_done: got valid=%b rdata=%h want 1/11112222", if_valid, if_rdata); end
        mem_ack = 1'b0; if_req = 1'b0;
        tick();
    endtask

    // Six contested grants: DM x4, then IF (streak saturated), then DM again (streak cleared).
    task automatic test_streak();
        logic exp_dm;
        for (int k = 0; k < 6; k++) begin
            exp_dm = (k != 4);
            if_req = 1'b1; if_addr = 32'h500;
            dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h55;
            tick();
            n_cmp++; if (mem_we !== exp_dm || mem_addr !== (exp_dm ? 32'h200 : 32'h500)) begin n_fail++; $display("FAIL t2_grant%0d: got we=%b addr=%h want we=%b", k, mem_we, mem_addr, exp_dm); end
            if (exp_dm) begin
                n_cmp++; if (mem_wdata !== 32'h55) begin n_fail++; $display("FAIL t2_wdata%0d: got %h want 55", k, mem_wdata); end
            end
            mem_ack = 1'b1; mem_rdata = 32'hABCD0000 + 32'(k);
            tick();
            n_cmp++; if ({dm_valid, if_valid} !== {exp_dm, ~exp_dm}) begin n_fail++; $display("FAIL t2_valid%0d: got dm/if=%b want %b", k, {dm_valid, if_valid}, {exp_dm, ~exp_dm}); end
            if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
            tick();
        end
        n_cmp++; if (dm_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL t2_store_hold: got %h want cafef00d", dm_rdata); end
        n_cmp++; if (if_rdata !== 32'hABCD0004) begin n_fail++; $display("FAIL t2_if_rdata: got %h want abcd0004", if_rdata); end
    endtask

    task automatic test_timeout();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h700;
        tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL t4_grant: got %b want 1", mem_req); end
        for (int i = 0; i < 15; i++) tick();
        n_cmp++; if (mem_req !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL t4_last_wait: got req=%b err=%b want 1/0", mem_req, err); end
        tick();
        n_cmp++; if (err !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL t4_err: got err=%b req=%b want 1/0", err, mem_req); end
        n_cmp++; if ({if_stall, dm_stall} !== 2'b11) begin n_fail++; $display("FAIL t4_stall: got %b want 11", {if_stall, dm_stall}); end
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        tick();
        n_cmp++; if (dm_valid !== 1'b0 || err !== 1'b1 || dm_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL t4_late_ack: got valid=%b err=%b rdata=%h want 0/1/cafef00d", dm_valid, err, dm_rdata); end
        mem_ack = 1'b0; dm_req = 1'b0;
        tick();
        n_cmp++; if (err !== 1'b1 || if_stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL t4_sticky: got err=%b istall=%b req=%b want 1/1/0", err, if_stall, mem_req); end
    endtask

    task automatic test_reset_mid_access();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL t5_err_clear: got %b want 0", err); end
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h800;
        tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL t5_grant: got %b want 1", mem_req); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL t5_async: got req=%b addr=%h want 0/0", mem_req, mem_addr); end
        n_cmp++; if (dm_valid !== 1'b0 || dm_rdata !== 32'h0 || if_rdata !== 32'h0) begin n_fail++; $display("FAIL t5_outs: got valid=%b rdata=%h/%h want 0/0/0", dm_valid, dm_rdata, if_rdata); end
        #1 rst = 1'b0; dm_req = 1'b0;
        tick();
        n_cmp++; if (dm_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL t5_abandon: got valid=%b req=%b want 0/0", dm_valid, mem_req); end
        if_req = 1'b1; if_addr = 32'h600;
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin n_fail++; $display("FAIL t5_next_grant: got req=%b addr=%h want 1/600", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL t5_next_done: got valid=%b rdata=%h want 1/0badf00d", if_valid, if_rdata); end
        mem_ack = 1'b0; if_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_stray_ack();
        test_back_to_back();
        test_streak();
        test_timeout();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
